pulse_period_meter: RTL and testbench
=====================================

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, bit width of the period counter and the period output.
REQ-002 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: pulse_in  input  1  pulse train to measure; one event per rising edge of the level.
REQ-005 SHALL have port: period  output  WIDTH  last measured edge-to-edge interval, in clock cycles.
REQ-006 SHALL have port: period_valid  output  1  one-cycle strobe when period updates.
REQ-007 SHALL have port: locked  output  1  high while the current period is a valid measurement.
REQ-008 SHALL have port: overflow  output  1  sticky flag; an interval exceeded 2^WIDTH-1 cycles.

Function
REQ-009 SHALL define event = pulse_in sampled high at a clock edge after being sampled low at the previous edge; a level held high counts once.
REQ-010 SHALL implement FSM states IDLE (no event yet), ARMED (one event seen, no valid interval), LOCKED (valid interval held).
REQ-011 SHALL, in IDLE on event, load count=1 and go to ARMED; period unchanged, no strobe.
REQ-012 SHALL, in ARMED or LOCKED with no event, increment count by 1 per cycle, saturating at 2^WIDTH-1.
REQ-013 SHALL, on event with count not saturated, load period=count, pulse period_valid for exactly one cycle, load count=1, and enter LOCKED.
REQ-014 SHALL, on event with count saturated, set overflow, leave period unchanged, suppress period_valid, load count=1, and enter ARMED.
REQ-015 SHALL, when count saturates without an event, set overflow and go to ARMED immediately (locked low next cycle).
REQ-016 SHALL drive locked high iff state is LOCKED.
REQ-017 SHALL register all outputs; period/period_valid appear the cycle after the edge that sampled the event.
REQ-018 SHALL, given a source emitting a 1-cycle pulse every N+1 cycles, report period=N+1 from the second event onward.
REQ-019 SHALL make overflow sticky until reset; it does not block later valid measurements.

Reset
REQ-020 SHALL, on reset assertion, asynchronously force state=IDLE, count=0, period=0, period_valid=0, locked=0, overflow=0, edge-history register=0.
REQ-021 SHALL discard any in-progress interval on reset mid-measurement; the first event after release only re-arms.
REQ-022 SHALL NOT detect an event if pulse_in is already high on the first edge after reset release; a low-to-high transition is needed.

Configuration
REQ-023 SHALL honour macro PULSE_SYNC_EN: when defined, pulse_in passes through a two-flop synchronizer (reset to 0) before edge detection, adding 2 cycles of latency to period_valid; reported period values are unchanged.
REQ-024 SHALL, without PULSE_SYNC_EN, sample pulse_in directly; pulse_in must then be synchronous to clock.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, ARMED, LOCKED) and the default WIDTH constant in shared package pulse_meter_pkg.
REQ-026 SHALL put synchronizer plus edge detection in one sub-module, pulse_edge_detect, which outputs a one-cycle event.

Verification
REQ-027 SHALL cover: 1-cycle pulses every 5 cycles -> first event no strobe; second event gives period=5, period_valid for 1 cycle, locked=1; period stays 5 on every later event.
REQ-028 SHALL cover: pulse_in held high 10 cycles, low 10 cycles, repeated -> one event per high phase, period=20.
REQ-029 SHALL cover: WIDTH=8, one event then silence -> at count=255 overflow=1 and locked=0; next event gives no strobe and re-arms; a following event 7 cycles later gives period=7 with overflow still 1.
REQ-030 SHALL cover: reset asserted mid-interval while locked with period=5 -> all outputs 0 at once; after release, two events 9 cycles apart give period=9.
REQ-031 SHALL cover: PULSE_SYNC_EN defined, events every 5 cycles -> period=5 with period_valid 2 cycles later than the non-synchronized build.
REQ-032 SHALL cover: pulses every 3 cycles, then switching to every 12 cycles -> period changes 3 to 12 on the first long interval, with no intermediate value.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse period meter.
// Build option: define PULSE_SYNC_EN to add a two-flop input synchronizer.
package pulse_meter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } meter_state_t;

`ifdef PULSE_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  // Edges after reset release before the edge history holds a real sample.
  localparam int PRIME_DEPTH = SYNC_STAGES + 1;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for pulse_in, with an optional two-flop synchronizer
// in front of it when PULSE_SYNC_EN is defined.
module pulse_edge_detect
  import pulse_meter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic pulse_in,
  output logic pulse_event
);

  logic                   sampled;
  logic                   prev_level;
  logic [PRIME_DEPTH-1:0] prime_sr;

`ifdef PULSE_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], pulse_in};
    end
  end

  assign sampled = sync_ff[1];
`else
  assign sampled = pulse_in;
`endif

  // An event needs a real low sample first, so a level that is already
  // high when reset is released does not count as an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_level <= 1'b0;
      prime_sr   <= '0;
    end else begin
      prev_level <= sampled;
      prime_sr   <= (prime_sr << 1) | PRIME_DEPTH'(1);
    end
  end

  assign pulse_event = prime_sr[PRIME_DEPTH-1] & sampled & ~prev_level;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the edge-to-edge interval of pulse_in in clock cycles.
// Build option: PULSE_SYNC_EN adds two cycles of input latency.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [WIDTH-1:0] COUNT_NEAR = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  meter_state_t     state;
  logic [WIDTH-1:0] count;
  logic             pulse_event;

  pulse_edge_detect u_edge (
    .clock       (clock),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .pulse_event (pulse_event)
  );

  // A saturated count means the interval is unmeasurable: flag overflow and
  // fall back to ARMED so the next event starts a fresh interval.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pulse_event) begin
            count  <= COUNT_ONE;
            state  <= ARMED;
            locked <= 1'b0;
          end
        end
        ARMED, LOCKED: begin
          if (pulse_event) begin
            count <= COUNT_ONE;
            if (count == COUNT_MAX) begin
              overflow <= 1'b1;
              state    <= ARMED;
              locked   <= 1'b0;
            end else begin
              period       <= count;
              period_valid <= 1'b1;
              state        <= LOCKED;
              locked       <= 1'b1;
            end
          end else if (count != COUNT_MAX) begin
            count <= count + COUNT_ONE;
            if (count == COUNT_NEAR) begin
              overflow <= 1'b1;
              state    <= ARMED;
              locked   <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed self-checking bench for pulse_period_meter (WIDTH=32 and WIDTH=8).
// Honours PULSE_SYNC_EN by expecting two extra cycles of strobe latency.
module tb_pulse_period_meter;

`ifdef PULSE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        pulse_a = 1'b0;
  logic        pulse_b = 1'b0;
  logic [31:0] period_a;
  logic        valid_a, locked_a, ovf_a;
  logic [7:0]  period_b;
  logic        valid_b, locked_b, ovf_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   a_q[$];
  int   a_double;
  logic a_prev_valid;
  int   a_first_cyc;
  int   b_strobes;
  int   b_last;

  always #5 clock = ~clock;

  pulse_period_meter u_dut_a (
    .clock        (clock),
    .reset        (reset),
    .pulse_in     (pulse_a),
    .period       (period_a),
    .period_valid (valid_a),
    .locked       (locked_a),
    .overflow     (ovf_a)
  );

  pulse_period_meter #(.WIDTH(8)) u_dut_b (
    .clock        (clock),
    .reset        (reset),
    .pulse_in     (pulse_b),
    .period       (period_b),
    .period_valid (valid_b),
    .locked       (locked_b),
    .overflow     (ovf_b)
  );

  // Each step drives one input sample, lets one rising edge pass, then
  // records any strobes observed 1 time unit after that edge.
  task automatic step(input logic pa, input logic pb);
    pulse_a = pa;
    pulse_b = pb;
    @(posedge clock);
    #1;
    cyc++;
    if (valid_a) begin
      if (a_q.size() == 0) a_first_cyc = cyc;
      a_q.push_back(int'(period_a));
      if (a_prev_valid) a_double++;
    end
    a_prev_valid = valid_a;
    if (valid_b) begin
      b_strobes++;
      b_last = int'(period_b);
    end
  endtask

  task automatic clear_stats();
    a_q.delete();
    a_double     = 0;
    a_prev_valid = 1'b0;
    a_first_cyc  = -1;
    b_strobes    = 0;
    b_last       = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic pulse_train(input int gap, input int events);
    repeat (events) begin
      step(1'b1, 1'b0);
      repeat (gap - 1) step(1'b0, 1'b0);
    end
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    @(posedge clock);
    #1;
    checks++;
    if (period_a !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_period: got %0d expected 0", period_a);
    end
    checks++;
    if ({valid_a, locked_a, ovf_a} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags_a: got %b expected 000", {valid_a, locked_a, ovf_a});
    end
    checks++;
    if ({period_b, valid_b, locked_b, ovf_b} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_b: got %h expected 0", {period_b, valid_b, locked_b, ovf_b});
    end
  endtask

  task automatic test_short_pulses();
    int start_cyc;
    int bad;
    apply_reset();
    idle(3);
    start_cyc = cyc;
    pulse_train(5, 6);
    idle(4);
    bad = 0;
    foreach (a_q[i]) if (a_q[i] != 5) bad++;
    checks++;
    if (a_q.size() !== 5) begin
      errors++;
      $display("[TB] FAIL short_strobes: got %0d expected 5", a_q.size());
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL short_period: got %0d non-5 values expected 0", bad);
    end
    checks++;
    if (a_double !== 0) begin
      errors++;
      $display("[TB] FAIL short_strobe_width: got %0d long strobes expected 0", a_double);
    end
    checks++;
    if (locked_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_locked: got %b expected 1", locked_a);
    end
    checks++;
    if (a_first_cyc - (start_cyc + 6) !== LAT) begin
      errors++;
      $display("[TB] FAIL short_latency: got %0d expected %0d", a_first_cyc - (start_cyc + 6), LAT);
    end
  endtask

  task automatic test_level_input();
    int bad;
    apply_reset();
    idle(2);
    repeat (4) begin
      repeat (10) step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
    end
    idle(4);
    bad = 0;
    foreach (a_q[i]) if (a_q[i] != 20) bad++;
    checks++;
    if (a_q.size() !== 3 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL level_period: got %0d strobes %0d bad expected 3 strobes 0 bad",
               a_q.size(), bad);
    end
  endtask

  task automatic test_early_high();
    reset   = 1'b1;
    pulse_a = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_stats();
    repeat (3) step(1'b1, 1'b0);
    idle(3);
    pulse_train(6, 2);
    idle(5);
    checks++;
    if (a_q.size() !== 1 || (a_q.size() == 1 && a_q[0] != 6)) begin
      errors++;
      $display("[TB] FAIL early_high: got %0d strobes first %0d expected 1 strobe of 6",
               a_q.size(), (a_q.size() > 0) ? a_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    idle(2);
    pulse_train(5, 3);
    idle(2);
    checks++;
    if (locked_a !== 1'b1 || period_a !== 32'd5) begin
      errors++;
      $display("[TB] FAIL mid_prelock: got locked %b period %0d expected 1 and 5", locked_a, period_a);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (period_a !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_async_period: got %0d expected 0", period_a);
    end
    checks++;
    if ({valid_a, locked_a, ovf_a} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_async_flags: got %b expected 000", {valid_a, locked_a, ovf_a});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_stats();
    idle(3);
    pulse_train(9, 2);
    idle(5);
    checks++;
    if (a_q.size() !== 1 || (a_q.size() == 1 && a_q[0] != 9)) begin
      errors++;
      $display("[TB] FAIL mid_rearm: got %0d strobes first %0d expected 1 strobe of 9",
               a_q.size(), (a_q.size() > 0) ? a_q[0] : -1);
    end
  endtask

  task automatic test_overflow();
    int mark;
    apply_reset();
    idle(2);
    step(1'b0, 1'b1);
    idle(3);
    step(1'b0, 1'b1);
    repeat (253 + LAT) step(1'b0, 1'b0);
    checks++;
    if (b_strobes !== 1 || b_last !== 4) begin
      errors++;
      $display("[TB] FAIL ovf_first_lock: got %0d strobes period %0d expected 1 and 4", b_strobes, b_last);
    end
    checks++;
    if ({locked_b, ovf_b} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ovf_before_sat: got locked,ovf %b expected 10", {locked_b, ovf_b});
    end
    step(1'b0, 1'b0);
    checks++;
    if ({locked_b, ovf_b} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ovf_at_sat: got locked,ovf %b expected 01", {locked_b, ovf_b});
    end
    idle(10);
    mark = b_strobes;
    step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    checks++;
    if (b_strobes !== mark || locked_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_rearm: got %0d new strobes locked %b expected 0 and 0",
               b_strobes - mark, locked_b);
    end
    step(1'b0, 1'b1);
    idle(4);
    checks++;
    if (b_strobes !== mark + 1 || b_last !== 7) begin
      errors++;
      $display("[TB] FAIL ovf_recover: got %0d new strobes period %0d expected 1 and 7",
               b_strobes - mark, b_last);
    end
    checks++;
    if ({locked_b, ovf_b} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got locked,ovf %b expected 11", {locked_b, ovf_b});
    end
  endtask

  task automatic test_switch();
    int exp_q[$];
    int bad;
    exp_q = '{3, 3, 3, 3, 3, 12, 12};
    apply_reset();
    idle(2);
    pulse_train(3, 5);
    pulse_train(12, 3);
    idle(4);
    checks++;
    if (a_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL switch_count: got %0d expected %0d", a_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= a_q.size() || a_q[i] != exp_q[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL switch_sequence: got %0d wrong entries expected 0", bad);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_short_pulses();
    test_level_input();
    test_early_high();
    test_reset_mid();
    test_overflow();
    test_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
